// File: rtl/alu_resp_tx_pkg.sv
// alu_resp_tx_pkg: shared opcodes, header size and state encoding for the response framer
package alu_resp_tx_pkg;
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'hAC;
  localparam logic [7:0] OP_DIV  = 8'hD1;
  localparam int HDR_BYTES = 4;
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECK} resp_state_e;
endpackage

// File: rtl/alu_resp_tx.sv
// alu_resp_tx: frames one ALU result into opcode/reserved/LEN16/payload bytes for UART TX
//   clk, rst (async, active-low)
//   result_valid_i/result_ready_o : result handshake, ready only while IDLE
//   opcode_i, result_i, result_len_i : captured on accept, length clamped to MAX_BYTES
//   tx_data_o/tx_valid_o/tx_ready_i : registered byte stream, held while not ready
//   busy_o : packet in progress
//   Define ALU_RESP_CHECKSUM_EN to append an XOR-of-payload byte (counted in LEN).
module alu_resp_tx
  import alu_resp_tx_pkg::*;
#(
  parameter int         MAX_BYTES = 8,
  parameter logic [7:0] RSVD_BYTE = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   result_valid_i,
  output logic                   result_ready_o,
  input  logic [7:0]             opcode_i,
  input  logic [8*MAX_BYTES-1:0] result_i,
  input  logic [3:0]             result_len_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic                   busy_o
);
`ifdef ALU_RESP_CHECKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif
  resp_state_e state;
  logic [8*MAX_BYTES-1:0] data_q;
  logic [3:0] len_q, cnt, len_c;
  logic [15:0] pkt_len;
  logic [7:0] hdr_nxt;
  logic xfer, hdr_last, load_pl;
  assign result_ready_o = state == IDLE;
  assign busy_o = state != IDLE;
  // In HEADER cnt indexes the byte on the wire; in PAYLOAD it counts bytes still to load.
  always_comb begin
    xfer = tx_valid_o && tx_ready_i;
    len_c = result_len_i > 4'(MAX_BYTES) ? 4'(MAX_BYTES) : result_len_i;
    pkt_len = 16'(HDR_BYTES) + 16'(len_q) + 16'(CHK_BYTES);
    hdr_nxt = cnt == 4'd0 ? RSVD_BYTE : cnt == 4'd1 ? pkt_len[7:0] : pkt_len[15:8];
    hdr_last = cnt == 4'(HDR_BYTES - 1);
    load_pl = xfer && ((state == HEADER && hdr_last && len_q != 4'd0) || (state == PAYLOAD && cnt != 4'd0));
  end
`ifdef ALU_RESP_CHECKSUM_EN
  logic [7:0] chk_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chk_q <= 8'h00;
    else if (state == IDLE) chk_q <= 8'h00;
    else if (load_pl) chk_q <= chk_q ^ data_q[7:0];
  end
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      data_q <= '0;
      len_q <= 4'd0;
      cnt <= 4'd0;
      tx_data_o <= 8'h00;
      tx_valid_o <= 1'b0;
    end else if (state == IDLE) begin
      if (result_valid_i) begin
        state <= HEADER;
        data_q <= result_i;
        len_q <= len_c;
        cnt <= 4'd0;
        tx_data_o <= opcode_i;
        tx_valid_o <= 1'b1;
      end
    end else if (load_pl) begin
      state <= PAYLOAD;
      tx_data_o <= data_q[7:0];
      data_q <= data_q >> 8;
      cnt <= state == HEADER ? len_q - 4'd1 : cnt - 4'd1;
    end else if (xfer) begin
      if (state == HEADER && !hdr_last) begin
        cnt <= cnt + 4'd1;
        tx_data_o <= hdr_nxt;
      end
`ifdef ALU_RESP_CHECKSUM_EN
      else if (state != CHECK) begin
        state <= CHECK;
        tx_data_o <= chk_q;
      end
`endif
      else begin
        state <= IDLE;
        tx_valid_o <= 1'b0;
        tx_data_o <= 8'h00;
      end
    end
  end
endmodule

// File: tb/tb_alu_resp_tx.sv
// tb_alu_resp_tx: directed framing, backpressure, length, reset and back-to-back checks
module tb_alu_resp_tx;
  import alu_resp_tx_pkg::*;
`ifdef ALU_RESP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic result_valid_i = 1'b0;
  logic result_ready_o;
  logic [7:0] opcode_i = 8'h00;
  logic [63:0] result_i = '0;
  logic [3:0] result_len_i = 4'd0;
  logic [7:0] tx_data_o;
  logic tx_valid_o;
  logic tx_ready_i = 1'b1;
  logic busy_o;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_x = 0;
  int n_acc = 0;
  int acc_gap = 0;
  logic hold = 1'b0;
  logic [7:0] hold_d = 8'h00;
  bq_t got;
  alu_resp_tx dut (
    .clk(clk), .rst(rst), .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
    .opcode_i(opcode_i), .result_i(result_i), .result_len_i(result_len_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      if (hold) begin
        check("hold_valid", tx_valid_o, 1'b1);
        check("hold_data", tx_data_o, hold_d);
      end
      if (tx_valid_o && tx_ready_i) begin
        got.push_back(tx_data_o);
        last_x = cyc;
      end
      if (result_valid_i && result_ready_o) begin
        n_acc++;
        acc_gap = cyc - last_x;
      end
      hold = tx_valid_o && !tx_ready_i;
      hold_d = tx_data_o;
    end else hold = 1'b0;
  end
  function automatic bq_t model(input logic [7:0] op, input logic [63:0] r, input logic [3:0] l);
    bq_t q;
    int n;
    logic [7:0] x;
    logic [15:0] len;
    n = l > 4'd8 ? 8 : int'(l);
    len = 16'(4 + n + CK);
    x = 8'h00;
    q.push_back(op);
    q.push_back(8'h00);
    q.push_back(len[7:0]);
    q.push_back(len[15:8]);
    for (int i = 0; i < n; i++) begin
      q.push_back(r[8*i+:8]);
      x ^= r[8*i+:8];
    end
    if (CK == 1) q.push_back(x);
    return q;
  endfunction
  task automatic drive(input logic [7:0] op, input logic [63:0] r, input logic [3:0] l);
    opcode_i = op;
    result_i = r;
    result_len_i = l;
    result_valid_i = 1'b1;
  endtask
  task automatic cmp_q(input string tag, input bq_t e);
    check({tag, "_count"}, 64'(got.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < got.size(); i++) check($sformatf("%s_b%0d", tag, i), got[i], e[i]);
  endtask
  task automatic run_pkt(input string tag, input logic [7:0] op, input logic [63:0] r, input logic [3:0] l, input int bp);
    logic done;
    done = 1'b0;
    got.delete();
    @(negedge clk);
    drive(op, r, l);
    tx_ready_i = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      result_valid_i = 1'b0;
      if (!busy_o) done = 1'b1;
      else tx_ready_i = bp != 0 ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
    end
    tx_ready_i = 1'b1;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_ready"}, result_ready_o, 1'b1);
    cmp_q(tag, model(op, r, l));
  endtask
  initial begin
    bq_t e, eb;
    logic done;
    #1;
    check("rst_valid", tx_valid_o, 1'b0);
    check("rst_data", tx_data_o, 8'h00);
    check("rst_busy", busy_o, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    check("rst_ready", result_ready_o, 1'b1);
    // basic framing with exact per-cycle timing
    e = '{8'hAD, 8'h00, 8'(8 + CK), 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    if (CK == 1) e.push_back(8'h08);
    @(negedge clk);
    drive(OP_ADD, 64'h0000_0000_1234_5678, 4'd4);
    for (int i = 0; i < e.size(); i++) begin
      @(negedge clk);
      result_valid_i = 1'b0;
      check($sformatf("c1_valid%0d", i), tx_valid_o, 1'b1);
      check($sformatf("c1_data%0d", i), tx_data_o, e[i]);
      check($sformatf("c1_rdy%0d", i), result_ready_o, 1'b0);
    end
    @(negedge clk);
    check("c1_ready_after", result_ready_o, 1'b1);
    check("c1_valid_after", tx_valid_o, 1'b0);
    check("c1_busy_after", busy_o, 1'b0);
    run_pkt("bp", OP_ADD, 64'h0000_0000_1234_5678, 4'd4, 1);
    run_pkt("len0", OP_ECHO, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 0);
    check("len0_lenlo", got.size() > 2 ? got[2] : 8'hXX, 8'(4 + CK));
    run_pkt("len15", OP_MUL, 64'h8877_6655_4433_2211, 4'd15, 1);
    check("len15_lenlo", got.size() > 2 ? got[2] : 8'hXX, 8'(12 + CK));
    // reset after the fifth byte transfer
    got.delete();
    @(negedge clk);
    drive(OP_ADD, 64'h0000_0000_1234_5678, 4'd4);
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_valid", tx_valid_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_data", tx_data_o, 8'h00);
    check("mid_rst_count", 64'(got.size()), 64'd5);
    @(negedge clk);
    result_valid_i = 1'b0;
    rst = 1'b1;
    check("mid_rst_ready", result_ready_o, 1'b1);
    run_pkt("post_rst", OP_DIV, 64'h0000_0000_00C0_FFEE, 4'd3, 0);
    // back-to-back with valid held high and inputs changed mid-packet
    got.delete();
    n_acc = 0;
    done = 1'b0;
    @(negedge clk);
    drive(OP_ADD, 64'h0000_0000_0000_BEEF, 4'd2);
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (n_acc == 1) drive(OP_DIV, 64'h0000_0000_0055_AA11, 4'd3);
      if (n_acc >= 2) begin
        result_valid_i = 1'b0;
        if (!busy_o) done = 1'b1;
      end
    end
    check("b2b_done", done, 1'b1);
    check("b2b_accepts", 64'(n_acc), 64'd2);
    check("b2b_gap", 64'(acc_gap), 64'd1);
    e = model(OP_ADD, 64'h0000_0000_0000_BEEF, 4'd2);
    eb = model(OP_DIV, 64'h0000_0000_0055_AA11, 4'd3);
    foreach (eb[i]) e.push_back(eb[i]);
    cmp_q("b2b", e);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
